// File: rtl/usr_pkg.sv
// usr_pkg: shared sel/op codes and sequencer state encoding
// for the universal shift register controller.
package usr_pkg;

  localparam logic [1:0] SEL_HOLD = 2'b00;
  localparam logic [1:0] SEL_SHR  = 2'b01;
  localparam logic [1:0] SEL_SHL  = 2'b10;
  localparam logic [1:0] SEL_LOAD = 2'b11;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_LOAD  = 3'd1;
  localparam logic [2:0] ST_SHIFT = 3'd2;
  localparam logic [2:0] ST_HOLD  = 3'd3;
  localparam logic [2:0] ST_DONE  = 3'd4;

endpackage

// File: rtl/usr_seq_cnt.sv
// usr_seq_cnt: loadable down-counter shared by SHIFT and HOLD,
// flags the cycle holding the final unit of work.
module usr_seq_cnt #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             dec_en,
  output logic             last
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // load wins over decrement; never wraps below zero
  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (dec_en && (cnt_q != '0)) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  // count register
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign last = (cnt_q == {{(CNT_W-1){1'b0}}, 1'b1});

endmodule

// File: rtl/usr_seq_ctrl.sv
// usr_seq_ctrl: one-at-a-time command sequencer driving the
// sel/data/serial inputs of a universal shift register.
module usr_seq_ctrl
  import usr_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd_op,
  input  logic [CNT_W-1:0] cmd_count,
  input  logic [WIDTH-1:0] cmd_data,
  input  logic             sin_valid,
  input  logic             sin_data,
  output logic             sin_ready,
  output logic [1:0]       usr_sel,
  output logic [WIDTH-1:0] usr_data_in,
  output logic             usr_sl_data,
  output logic             usr_sr_data,
  output logic             busy,
  output logic             done
);

  logic [2:0]       state_q, state_d;
  logic [1:0]       op_q, op_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic             cnt_load;
  logic             cnt_dec;
  logic             cnt_last;
  logic             in_shift;

  usr_seq_cnt #(.CNT_W(CNT_W)) u_cnt (
    .clk      (clk),
    .reset    (reset),
    .load     (cnt_load),
    .load_val (cmd_count),
    .dec_en   (cnt_dec),
    .last     (cnt_last)
  );

  // next-state, command latching and counter control
  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    data_d   = data_q;
    cnt_load = 1'b0;
    cnt_dec  = 1'b0;
    unique case (1'b1)
      (state_q == ST_IDLE): begin
        if (cmd_valid) begin
          op_d = cmd_op;
          if (cmd_op == SEL_LOAD) begin
            data_d  = cmd_data;
            state_d = ST_LOAD;
          end else begin
            cnt_load = 1'b1;
            if (cmd_count == '0) begin
              state_d = ST_DONE;
            end else if (cmd_op == SEL_HOLD) begin
              state_d = ST_HOLD;
            end else begin
              state_d = ST_SHIFT;
            end
          end
        end
      end
      (state_q == ST_LOAD): begin
        state_d = ST_DONE;
      end
      (state_q == ST_SHIFT): begin
        if (sin_valid) begin
          cnt_dec = 1'b1;
          if (cnt_last) begin
            state_d = ST_DONE;
          end
        end
      end
      (state_q == ST_HOLD): begin
        cnt_dec = 1'b1;
        if (cnt_last) begin
          state_d = ST_DONE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // state and latched command registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      op_q    <= SEL_HOLD;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      data_q  <= data_d;
    end
  end

  assign in_shift = (state_q == ST_SHIFT);

  // shift register drive; SHIFT sel follows sin_valid
  always_comb begin
    usr_sel = SEL_HOLD;
    if (state_q == ST_LOAD) begin
      usr_sel = SEL_LOAD;
    end else if (in_shift && sin_valid) begin
      usr_sel = op_q;
    end
  end

  assign usr_data_in = data_q;
  assign sin_ready   = in_shift && sin_valid;
  assign usr_sr_data = in_shift && (op_q == SEL_SHR) && sin_data;
  assign usr_sl_data = in_shift && (op_q == SEL_SHL) && sin_data;
  assign cmd_ready   = (state_q == ST_IDLE);
  assign busy        = (state_q != ST_IDLE);
  assign done        = (state_q == ST_DONE);

endmodule

// File: tb/tb_usr_seq_ctrl.sv
// tb_usr_seq_ctrl: directed vectors for the sequencer with a
// 4-bit universal shift register model as the datapath.
module tb_usr_seq_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [1:0] cmd_op;
  logic [7:0] cmd_count;
  logic [3:0] cmd_data;
  logic       sin_valid;
  logic       sin_data;
  logic       sin_ready;
  logic [1:0] usr_sel;
  logic [3:0] usr_data_in;
  logic       usr_sl_data;
  logic       usr_sr_data;
  logic       busy;
  logic       done;
  logic [3:0] sr;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  usr_seq_ctrl #(.WIDTH(4), .CNT_W(8)) dut (
    .clk         (clk),
    .reset       (reset),
    .cmd_valid   (cmd_valid),
    .cmd_ready   (cmd_ready),
    .cmd_op      (cmd_op),
    .cmd_count   (cmd_count),
    .cmd_data    (cmd_data),
    .sin_valid   (sin_valid),
    .sin_data    (sin_data),
    .sin_ready   (sin_ready),
    .usr_sel     (usr_sel),
    .usr_data_in (usr_data_in),
    .usr_sl_data (usr_sl_data),
    .usr_sr_data (usr_sr_data),
    .busy        (busy),
    .done        (done)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      sr <= 4'b0;
    end else begin
      case (usr_sel)
        2'b01:   sr <= {usr_sr_data, sr[3:1]};
        2'b10:   sr <= {sr[2:0], usr_sl_data};
        2'b11:   sr <= usr_data_in;
        default: sr <= sr;
      endcase
    end
  end

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic offer(input logic [1:0] op, input logic [7:0] cnt,
                       input logic [3:0] dat);
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_count = cnt;
    cmd_data  = dat;
  endtask

  logic [2:0] shr_bits;
  logic [3:0] shr_exp [3];

  initial begin
    reset     = 1'b1;
    cmd_valid = 1'b0;
    cmd_op    = 2'b00;
    cmd_count = 8'd0;
    cmd_data  = 4'd0;
    sin_valid = 1'b0;
    sin_data  = 1'b0;
    shr_bits  = 3'b101;
    shr_exp[0] = 4'b1101;
    shr_exp[1] = 4'b0110;
    shr_exp[2] = 4'b1011;
    cyc();
    cyc();
    reset = 1'b0;
    settle();
    chk("rst_sel", usr_sel, 2'b00);
    chk("rst_din", usr_data_in, 4'h0);
    chk("rst_rdy", cmd_ready, 1'b1);
    chk("rst_sinr", sin_ready, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);

    // LOAD 1011
    offer(2'b11, 8'd0, 4'b1011);
    settle();
    chk("ld_rdy", cmd_ready, 1'b1);
    cyc();
    cmd_valid = 1'b0;
    settle();
    chk("ld_sel", usr_sel, 2'b11);
    chk("ld_din", usr_data_in, 4'b1011);
    chk("ld_busy", busy, 1'b1);
    chk("ld_done0", done, 1'b0);
    cyc();
    chk("ld_sel2", usr_sel, 2'b00);
    chk("ld_done", done, 1'b1);
    chk("ld_rdy_d", cmd_ready, 1'b0);
    chk("ld_sr", sr, 4'b1011);
    cyc();
    chk("ld_rdy2", cmd_ready, 1'b1);
    chk("ld_done2", done, 1'b0);
    chk("ld_busy2", busy, 1'b0);

    // SHR 3 with bits 1,0,1
    offer(2'b01, 8'd3, 4'h0);
    cyc();
    cmd_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      sin_valid = 1'b1;
      sin_data  = shr_bits[i];
      settle();
      chk("shr_sel", usr_sel, 2'b01);
      chk("shr_sinr", sin_ready, 1'b1);
      chk("shr_srd", usr_sr_data, shr_bits[i]);
      chk("shr_sld", usr_sl_data, 1'b0);
      chk("shr_done0", done, 1'b0);
      cyc();
      chk("shr_sr", sr, shr_exp[i]);
    end
    sin_valid = 1'b0;
    settle();
    chk("shr_done", done, 1'b1);
    cyc();
    chk("shr_idle", cmd_ready, 1'b1);

    // SHL 2 with a two-cycle stall between bits
    offer(2'b10, 8'd2, 4'h0);
    cyc();
    cmd_valid = 1'b0;
    sin_valid = 1'b1;
    sin_data  = 1'b1;
    settle();
    chk("shl_sel", usr_sel, 2'b10);
    chk("shl_sld", usr_sl_data, 1'b1);
    chk("shl_srd", usr_sr_data, 1'b0);
    cyc();
    chk("shl_sr1", sr, 4'b0111);
    sin_valid = 1'b0;
    for (int i = 0; i < 2; i++) begin
      settle();
      chk("shl_stall_sel", usr_sel, 2'b00);
      chk("shl_stall_sinr", sin_ready, 1'b0);
      chk("shl_stall_busy", busy, 1'b1);
      chk("shl_stall_done", done, 1'b0);
      cyc();
    end
    sin_valid = 1'b1;
    sin_data  = 1'b0;
    settle();
    chk("shl_sel2", usr_sel, 2'b10);
    chk("shl_done0", done, 1'b0);
    cyc();
    sin_valid = 1'b0;
    chk("shl_sr2", sr, 4'b1110);
    chk("shl_done", done, 1'b1);
    cyc();

    // HOLD 5 with fill bits offered but not consumed
    offer(2'b00, 8'd5, 4'h0);
    cyc();
    cmd_valid = 1'b0;
    sin_valid = 1'b1;
    sin_data  = 1'b1;
    for (int i = 0; i < 5; i++) begin
      settle();
      chk("hld_sel", usr_sel, 2'b00);
      chk("hld_sinr", sin_ready, 1'b0);
      chk("hld_done0", done, 1'b0);
      cyc();
    end
    chk("hld_done", done, 1'b1);
    chk("hld_sinr_d", sin_ready, 1'b0);
    chk("hld_sr", sr, 4'b1110);
    cyc();
    sin_valid = 1'b0;

    // SHR count 0
    offer(2'b01, 8'd0, 4'h0);
    cyc();
    cmd_valid = 1'b0;
    settle();
    chk("z_done", done, 1'b1);
    chk("z_sel", usr_sel, 2'b00);
    cyc();
    chk("z_idle", cmd_ready, 1'b1);

    // reset in the second cycle of SHR 4
    offer(2'b01, 8'd4, 4'h0);
    cyc();
    cmd_valid = 1'b0;
    sin_valid = 1'b1;
    sin_data  = 1'b1;
    cyc();
    reset = 1'b1;
    cyc();
    reset     = 1'b0;
    sin_valid = 1'b0;
    settle();
    chk("ab_sel", usr_sel, 2'b00);
    chk("ab_rdy", cmd_ready, 1'b1);
    chk("ab_busy", busy, 1'b0);
    chk("ab_done", done, 1'b0);
    chk("ab_din", usr_data_in, 4'h0);
    offer(2'b11, 8'd0, 4'b0101);
    cyc();
    cmd_valid = 1'b0;
    settle();
    chk("ab_done1", done, 1'b0);
    chk("ab_ld_sel", usr_sel, 2'b11);
    cyc();
    chk("ab_done2", done, 1'b1);
    chk("ab_sr", sr, 4'b0101);
    cyc();

    // two queued commands, cmd_valid held high
    offer(2'b01, 8'd1, 4'h0);
    sin_valid = 1'b1;
    sin_data  = 1'b0;
    settle();
    chk("q_rdy0", cmd_ready, 1'b1);
    cyc();
    offer(2'b00, 8'd1, 4'h0);
    settle();
    chk("q_rdy_sh", cmd_ready, 1'b0);
    chk("q_sel_sh", usr_sel, 2'b01);
    cyc();
    sin_valid = 1'b0;
    settle();
    chk("q_rdy_dn", cmd_ready, 1'b0);
    chk("q_done1", done, 1'b1);
    chk("q_sr", sr, 4'b0010);
    cyc();
    chk("q_rdy_id", cmd_ready, 1'b1);
    chk("q_busy_id", busy, 1'b0);
    cyc();
    cmd_valid = 1'b0;
    settle();
    chk("q_hold_busy", busy, 1'b1);
    chk("q_hold_rdy", cmd_ready, 1'b0);
    chk("q_hold_sel", usr_sel, 2'b00);
    chk("q_hold_done0", done, 1'b0);
    cyc();
    chk("q_done2", done, 1'b1);
    cyc();
    chk("q_end_rdy", cmd_ready, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
